grid_cursor_controller: RTL and testbench

- Owns the edit cursor of the step-sequencer pattern grid, driven by the one-cycle Direction/Command pulses from the keyboard move decoder.
- Moves the cursor with wrap-around. On Command, runs a read-modify-write on the shared pattern RAM to toggle the step under the cursor.
- The pattern RAM holds one word per track row, one bit per step. It is shared with the playback engine through an external arbiter using a req/gnt handshake.

---
 rtl/grid_cursor_controller.sv | 203 ++++++++++++++++++++
 tb/tb_grid_cursor_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_cursor_controller.sv
// Edit cursor for the step-sequencer pattern grid: wrap-around cursor moves and
// a read-modify-write toggle of the step under the cursor through a req/gnt RAM port.
module grid_cursor_controller #(
  parameter int ROWS  = 4,
  parameter int STEPS = 16,
  parameter int ROW_W = 2,
  parameter int COL_W = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Enable,
  input  logic [3:0]       Direction,
  input  logic             Command,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [ROW_W-1:0] mem_addr,
  output logic [STEPS-1:0] mem_wdata,
  input  logic [STEPS-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy,
  output logic             toggle_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD_WAIT = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(STEPS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  function automatic logic [STEPS-1:0] step_mask(input logic [COL_W-1:0] col);
    logic [STEPS-1:0] m;
    m = {STEPS{1'b0}};
    for (int i = 0; i < STEPS; i++) begin
      if (col == COL_W'(i)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  state_t           state_q, state_d;
  logic [ROW_W-1:0] cursor_row_q, cursor_row_d;
  logic [COL_W-1:0] cursor_col_q, cursor_col_d;
  logic [ROW_W-1:0] tgt_row_q, tgt_row_d;
  logic [COL_W-1:0] tgt_col_q, tgt_col_d;
  logic [STEPS-1:0] rd_buf_q, rd_buf_d;
  logic             pending_q, pending_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [ROW_W-1:0] mem_addr_q, mem_addr_d;
  logic [STEPS-1:0] mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             toggle_done_q, toggle_done_d;
  logic             launch;

  // A queued toggle only survives while edit mode stays on.
  assign launch = Enable & (Command | pending_q);

  // Cursor movement: single one-hot pulse moves one cell with wrap-around.
  always_comb begin
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    if (Enable) begin
      case (Direction)
        4'b0001: cursor_row_d = (cursor_row_q == {ROW_W{1'b0}}) ? ROW_MAX : cursor_row_q - ROW_ONE;
        4'b0010: cursor_row_d = (cursor_row_q == ROW_MAX) ? {ROW_W{1'b0}} : cursor_row_q + ROW_ONE;
        4'b0100: cursor_col_d = (cursor_col_q == {COL_W{1'b0}}) ? COL_MAX : cursor_col_q - COL_ONE;
        4'b1000: cursor_col_d = (cursor_col_q == COL_MAX) ? {COL_W{1'b0}} : cursor_col_q + COL_ONE;
        default: begin
          cursor_row_d = cursor_row_q;
          cursor_col_d = cursor_col_q;
        end
      endcase
    end else begin
      cursor_row_d = cursor_row_q;
      cursor_col_d = cursor_col_q;
    end
  end

  // RMW sequencer next state and captured target/read data.
  always_comb begin
    state_d   = state_q;
    tgt_row_d = tgt_row_q;
    tgt_col_d = tgt_col_q;
    rd_buf_d  = rd_buf_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          tgt_row_d = cursor_row_q;
          tgt_col_d = cursor_col_q;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = RD_WAIT;
        end else begin
          state_d = REQ;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rd_buf_d = mem_rdata;
          state_d  = WRITE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-entry toggle queue; in IDLE it is either consumed by launch or was empty.
  always_comb begin
    pending_d = pending_q;
    if (!Enable) begin
      pending_d = 1'b0;
    end else if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (Command) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Outputs decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    mem_req_d     = (state_d == REQ) || (state_d == RD_WAIT) || (state_d == WRITE);
    mem_we_d      = (state_d == WRITE);
    busy_d        = mem_req_d;
    toggle_done_d = (state_d == DONE);
    if (mem_req_d) begin
      mem_addr_d = tgt_row_d;
    end else begin
      mem_addr_d = {ROW_W{1'b0}};
    end
    if (mem_we_d) begin
      mem_wdata_d = rd_buf_d ^ step_mask(tgt_col_d);
    end else begin
      mem_wdata_d = {STEPS{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= IDLE;
      cursor_row_q  <= {ROW_W{1'b0}};
      cursor_col_q  <= {COL_W{1'b0}};
      tgt_row_q     <= {ROW_W{1'b0}};
      tgt_col_q     <= {COL_W{1'b0}};
      rd_buf_q      <= {STEPS{1'b0}};
      pending_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ROW_W{1'b0}};
      mem_wdata_q   <= {STEPS{1'b0}};
      busy_q        <= 1'b0;
      toggle_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_row_q  <= cursor_row_d;
      cursor_col_q  <= cursor_col_d;
      tgt_row_q     <= tgt_row_d;
      tgt_col_q     <= tgt_col_d;
      rd_buf_q      <= rd_buf_d;
      pending_q     <= pending_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      toggle_done_q <= toggle_done_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cursor_row  = cursor_row_q;
  assign cursor_col  = cursor_col_q;
  assign busy        = busy_q;
  assign toggle_done = toggle_done_q;

endmodule

// File: tb/tb_grid_cursor_controller.sv
// Directed testbench for grid_cursor_controller with a small RAM/arbiter responder.
module tb_grid_cursor_controller;
  localparam int ROW_W = 2;
  localparam int COL_W = 4;
  localparam int STEPS = 16;

  logic             Clock = 1'b0;
  logic             nReset;
  logic             Enable;
  logic [3:0]       Direction;
  logic             Command;
  logic             mem_req;
  logic             mem_gnt;
  logic             mem_we;
  logic [ROW_W-1:0] mem_addr;
  logic [STEPS-1:0] mem_wdata;
  logic [STEPS-1:0] mem_rdata;
  logic             mem_rvalid;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;
  logic             busy;
  logic             toggle_done;

  logic             gnt_allow;
  logic             rv_allow;
  logic [STEPS-1:0] rd_value;
  logic             rd_done;
  int               wr_count = 0;
  logic [ROW_W-1:0] wr_log_addr [0:15];
  logic [STEPS-1:0] wr_log_data [0:15];
  int               checks = 0;
  int               failures = 0;

  grid_cursor_controller #(.ROWS(4), .STEPS(STEPS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .Clock(Clock), .nReset(nReset), .Enable(Enable), .Direction(Direction), .Command(Command),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy), .toggle_done(toggle_done)
  );

  always #5 Clock = ~Clock;

  // Arbiter grants in the same cycle as the request unless the bench holds it off.
  assign mem_gnt = mem_req & gnt_allow;

  // RAM responder: rvalid one cycle after the read issue, writes logged in order.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      rd_done    <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      if (!mem_req) begin
        rd_done <= 1'b0;
      end else if (mem_gnt && !mem_we && !rd_done && rv_allow) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rd_value;
        rd_done    <= 1'b1;
      end
      if (mem_req && mem_gnt && mem_we) begin
        wr_log_addr[wr_count[3:0]] <= mem_addr;
        wr_log_data[wr_count[3:0]] <= mem_wdata;
        wr_count <= wr_count + 1;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic move(input logic [3:0] dir);
    Direction = dir;
    tick();
    Direction = 4'b0000;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0) begin failures++; $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || toggle_done !== 1'b0) begin failures++; $display("FAIL reset_ctrl: req=%b we=%b busy=%b done=%b expected all 0", mem_req, mem_we, busy, toggle_done); end
    checks++; if (mem_addr !== 2'd0 || mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_bus: addr=%0d wdata=%h expected 0/0000", mem_addr, mem_wdata); end
    nReset = 1'b1;
    tick();
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL post_reset: got (%0d,%0d) busy=%b expected (0,0) busy=0", cursor_row, cursor_col, busy); end
  endtask

  task automatic test_cursor_wrap();
    Enable = 1'b1;
    move(4'b0001);
    checks++; if (cursor_row !== 2'd3 || cursor_col !== 4'd0) begin failures++; $display("FAIL up_wrap: got (%0d,%0d) expected (3,0)", cursor_row, cursor_col); end
    move(4'b0100);
    checks++; if (cursor_row !== 2'd3 || cursor_col !== 4'd15) begin failures++; $display("FAIL left_wrap: got (%0d,%0d) expected (3,15)", cursor_row, cursor_col); end
    move(4'b1000);
    checks++; if (cursor_row !== 2'd3 || cursor_col !== 4'd0) begin failures++; $display("FAIL right_wrap: got (%0d,%0d) expected (3,0)", cursor_row, cursor_col); end
    move(4'b0010);
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0) begin failures++; $display("FAIL down_wrap: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
  endtask

  task automatic test_no_move();
    move(4'b0010);
    move(4'b1000);
    checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd1) begin failures++; $display("FAIL plain_move: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
    move(4'b0011);
    checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd1) begin failures++; $display("FAIL multi_hot: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
    move(4'b0000);
    move(4'b1100);
    checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd1) begin failures++; $display("FAIL zero_or_lr: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
    Enable = 1'b0;
    move(4'b0010);
    checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd1) begin failures++; $display("FAIL disabled_move: got (%0d,%0d) expected (1,1)", cursor_row, cursor_col); end
    Enable = 1'b1;
  endtask

  // Command cycle is cycle 1; REQ, RD_WAIT, WRITE follow and toggle_done is high in cycle 5.
  task automatic test_toggle();
    int w0;
    move(4'b0010);
    for (int i = 0; i < 4; i++) move(4'b1000);
    checks++; if (cursor_row !== 2'd2 || cursor_col !== 4'd5) begin failures++; $display("FAIL setup_2_5: got (%0d,%0d) expected (2,5)", cursor_row, cursor_col); end
    w0 = wr_count;
    rd_value = 16'h0020;
    Command = 1'b1;
    tick();
    Command = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 2'd2 || busy !== 1'b1 || toggle_done !== 1'b0) begin failures++; $display("FAIL tog_req: req=%b we=%b addr=%0d busy=%b done=%b expected 1/0/2/1/0", mem_req, mem_we, mem_addr, busy, toggle_done); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_rvalid !== 1'b1) begin failures++; $display("FAIL tog_rdwait: req=%b we=%b rvalid=%b expected 1/0/1", mem_req, mem_we, mem_rvalid); end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || mem_wdata !== 16'h0000) begin failures++; $display("FAIL tog_write: we=%b addr=%0d wdata=%h expected 1/2/0000", mem_we, mem_addr, mem_wdata); end
    tick();
    checks++; if (toggle_done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL tog_done: done=%b req=%b we=%b busy=%b expected 1/0/0/0", toggle_done, mem_req, mem_we, busy); end
    checks++; if (wr_count !== w0 + 1 || wr_log_addr[w0] !== 2'd2 || wr_log_data[w0] !== 16'h0000) begin failures++; $display("FAIL tog_ram: writes=%0d addr=%0d data=%h expected %0d/2/0000", wr_count - w0, wr_log_addr[w0], wr_log_data[w0], 1); end
    tick();
    checks++; if (toggle_done !== 1'b0 || cursor_row !== 2'd2 || cursor_col !== 4'd5) begin failures++; $display("FAIL tog_after: done=%b cursor=(%0d,%0d) expected 0 (2,5)", toggle_done, cursor_row, cursor_col); end
  endtask

  task automatic test_gnt_stall();
    int  w0;
    logic found;
    move(4'b0001);
    for (int i = 0; i < 5; i++) move(4'b0100);
    checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd0) begin failures++; $display("FAIL setup_1_0: got (%0d,%0d) expected (1,0)", cursor_row, cursor_col); end
    w0 = wr_count;
    rd_value = 16'h0000;
    gnt_allow = 1'b0;
    Command = 1'b1;
    tick();
    Command = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || wr_count !== w0) begin failures++; $display("FAIL stall_hold cycle %0d: req=%b we=%b writes=%0d expected 1/0/0", i, mem_req, mem_we, wr_count - w0); end
      tick();
    end
    gnt_allow = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (toggle_done === 1'b1) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL stall_timeout: toggle_done=%b expected 1 within 20 cycles", found); end
    checks++; if (wr_count !== w0 + 1 || wr_log_addr[w0] !== 2'd1 || wr_log_data[w0] !== 16'h0001) begin failures++; $display("FAIL stall_ram: writes=%0d addr=%0d data=%h expected 1/1/0001", wr_count - w0, wr_log_addr[w0], wr_log_data[w0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_count;
    rd_value = 16'h0000;
    Command = 1'b1;
    tick();
    Command = 1'b0;
    Direction = 4'b0001;
    tick();
    Direction = 4'b1000; Command = 1'b1;
    tick();
    Direction = 4'b1000; Command = 1'b1;
    tick();
    Direction = 4'b1000; Command = 1'b0;
    tick();
    Direction = 4'b0000;
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd3) begin failures++; $display("FAIL b2b_cursor: got (%0d,%0d) expected (0,3)", cursor_row, cursor_col); end
    repeat (20) tick();
    checks++; if (wr_count !== w0 + 2) begin failures++; $display("FAIL b2b_count: writes=%0d expected 2", wr_count - w0); end
    checks++; if (wr_log_addr[w0] !== 2'd1 || wr_log_data[w0] !== 16'h0001) begin failures++; $display("FAIL b2b_first: addr=%0d data=%h expected 1/0001", wr_log_addr[w0], wr_log_data[w0]); end
    checks++; if (wr_log_addr[w0 + 1] !== 2'd0 || wr_log_data[w0 + 1] !== 16'h0008) begin failures++; $display("FAIL b2b_second: addr=%0d data=%h expected 0/0008", wr_log_addr[w0 + 1], wr_log_data[w0 + 1]); end
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy=%b req=%b expected 0/0", busy, mem_req); end
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    w0 = wr_count;
    rv_allow = 1'b0;
    Command = 1'b1;
    tick();
    Command = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_pre: req=%b busy=%b expected 1/1", mem_req, busy); end
    nReset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_async: req=%b busy=%b we=%b expected 0/0/0", mem_req, busy, mem_we); end
    tick();
    tick();
    nReset = 1'b1;
    rv_allow = 1'b1;
    repeat (10) tick();
    checks++; if (wr_count !== w0) begin failures++; $display("FAIL rst_nowrite: writes=%0d expected 0", wr_count - w0); end
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0 || busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rst_after: cursor=(%0d,%0d) busy=%b req=%b expected (0,0) 0 0", cursor_row, cursor_col, busy, mem_req); end
  endtask

  initial begin
    nReset = 1'b0;
    Enable = 1'b0;
    Direction = 4'b0000;
    Command = 1'b0;
    gnt_allow = 1'b1;
    rv_allow = 1'b1;
    rd_value = 16'h0000;
    test_reset();
    test_cursor_wrap();
    test_no_move();
    test_toggle();
    test_gnt_stall();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
